fuzz_crash_reporter: RTL

Downstream of the random fuzzer, this block turns a fuzzer halt into a byte stream a host can read. On the rising edge of either alarm it snapshots:
- the alarm type;
- the coverage score;
- the offending input/output vectors.

It then emits one framed, checksummed record over a valid/ready byte interface, typically feeding a UART or debug FIFO. It counts delivered records and flags triggers it had to drop.

---
 rtl/fuzz_crash_reporter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fuzz_crash_reporter.sv
// Snapshots a fuzzer alarm and streams it as a framed record over a valid/ready byte port.
// Define REPORTER_CSUM_EN to append an XOR checksum byte to every record.
module fuzz_crash_reporter #(
    parameter int         INPUT_WIDTH  = 256,
    parameter int         OUTPUT_WIDTH = 128,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alarm_hang,
    input  logic                    alarm_collision,
    input  logic [7:0]              coverage_score,
    input  logic [INPUT_WIDTH-1:0]  error_input,
    input  logic [OUTPUT_WIDTH-1:0] error_output,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [15:0]             report_count,
    output logic                    dropped
);

    localparam int IN_BYTES  = INPUT_WIDTH / 8;
    localparam int OUT_BYTES = OUTPUT_WIDTH / 8;
    localparam int HDR_BYTES = 3;
    localparam int SEG_A     = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
    localparam int SEG_MAX   = (SEG_A > HDR_BYTES) ? SEG_A : HDR_BYTES;
    localparam int IDX_W     = $clog2(SEG_MAX);
    localparam int IN_SEL_W  = $clog2(INPUT_WIDTH);
    localparam int OUT_SEL_W = $clog2(OUTPUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
`ifdef REPORTER_CSUM_EN
        , CHECKSUM = 2'd3
`endif
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    out_phase, out_phase_next;
    logic                    prev;
    logic                    trig;
    logic                    hs;
    logic                    last_hs;
    logic [7:0]              snap_type;
    logic [7:0]              snap_cov;
    logic [INPUT_WIDTH-1:0]  snap_in;
    logic [OUTPUT_WIDTH-1:0] snap_out;
    logic [IN_SEL_W-1:0]     in_sel;
    logic [OUT_SEL_W-1:0]    out_sel;
`ifdef REPORTER_CSUM_EN
    logic [7:0]              csum;
`endif

    assign trig     = (alarm_hang | alarm_collision) & ~prev;
    assign tx_valid = (state != IDLE);
    assign busy     = (state != IDLE);
    assign hs       = tx_valid & tx_ready;

    // Payload bytes go out MSB byte first, so the select counts down from the top.
    always_comb begin
        in_sel  = IN_SEL_W'(8 * (IN_BYTES - 1 - int'(idx)));
        out_sel = OUT_SEL_W'(8 * (OUT_BYTES - 1 - int'(idx)));
        tx_data = 8'h00;
        case (state)
            HEADER: begin
                if (idx == IDX_W'(0))
                    tx_data = SYNC_BYTE;
                else if (idx == IDX_W'(1))
                    tx_data = snap_type;
                else
                    tx_data = snap_cov;
            end
            PAYLOAD: begin
                if (out_phase)
                    tx_data = snap_out[out_sel +: 8];
                else
                    tx_data = snap_in[in_sel +: 8];
            end
`ifdef REPORTER_CSUM_EN
            CHECKSUM: tx_data = csum;
`endif
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        out_phase_next = out_phase;
        last_hs        = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_next     = HEADER;
                    idx_next       = '0;
                    out_phase_next = 1'b0;
                end
            end
            HEADER: begin
                if (hs) begin
                    if (idx == IDX_W'(HDR_BYTES - 1)) begin
                        state_next = PAYLOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (hs) begin
                    if (!out_phase) begin
                        if (idx == IDX_W'(IN_BYTES - 1)) begin
                            out_phase_next = 1'b1;
                            idx_next       = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else if (idx == IDX_W'(OUT_BYTES - 1)) begin
                        idx_next       = '0;
                        out_phase_next = 1'b0;
`ifdef REPORTER_CSUM_EN
                        state_next     = CHECKSUM;
`else
                        state_next     = IDLE;
                        last_hs        = 1'b1;
`endif
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
`ifdef REPORTER_CSUM_EN
            CHECKSUM: begin
                if (hs) begin
                    state_next = IDLE;
                    last_hs    = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_phase <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            out_phase <= out_phase_next;
        end
    end

    // Snapshot is taken only when idle; triggers during a record just mark the drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev         <= 1'b0;
            snap_type    <= 8'h00;
            snap_cov     <= 8'h00;
            snap_in      <= '0;
            snap_out     <= '0;
            report_count <= 16'h0000;
            dropped      <= 1'b0;
        end else begin
            prev <= alarm_hang | alarm_collision;
            if (trig && state == IDLE) begin
                snap_type <= {6'b0, alarm_collision, alarm_hang};
                snap_cov  <= coverage_score;
                snap_in   <= error_input;
                snap_out  <= error_output;
            end
            if (trig && state != IDLE)
                dropped <= 1'b1;
            if (last_hs)
                report_count <= report_count + 16'd1;
        end
    end

`ifdef REPORTER_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            csum <= 8'h00;
        else if (trig && state == IDLE)
            csum <= 8'h00;
        else if (hs && state != CHECKSUM)
            csum <= csum ^ tx_data;
    end
`endif

endmodule
